// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
// Shared definitions for the LFSR round-robin server:
//   - state_t       : server FSM states (IDLE, GRANT, SEED)
//   - LFSR_W        : default LFSR width
//   - LFSR_TAPS_DEF : default feedback mask (maximal length, period 31)
//   - LFSR_SEED_DEF : default reset / zero-substitute seed
//   - lfsr_step()   : one Fibonacci shift, feedback = XOR-reduce(v & taps)
// -----------------------------------------------------------------------------
package lfsr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        SEED  = 2'd2
    } state_t;

    localparam int unsigned       LFSR_W        = 5;
    localparam logic [LFSR_W-1:0] LFSR_TAPS_DEF = 5'b10010;
    localparam logic [LFSR_W-1:0] LFSR_SEED_DEF = 5'b00001;

    // Operates on a 32-bit container so any WIDTH up to 32 can share it;
    // bits at and above w are cleared in the result.
    function automatic logic [31:0] lfsr_step(input logic [31:0] v,
                                              input logic [31:0] taps,
                                              input int unsigned w);
        logic [31:0] mask;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return ((v << 1) | {31'd0, ^(v & taps)}) & mask;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// -----------------------------------------------------------------------------
// lfsr_core
// LFSR register with load / step / hold controls.
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset (register <= SEED)
//   i_load     in   load i_load_val (all-zero value replaced by SEED); wins over step
//   i_load_val in   value to load
//   i_step     in   advance one Fibonacci step
//   o_lfsr     out  current register value
// -----------------------------------------------------------------------------
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = LFSR_W,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_DEF,
    parameter logic [WIDTH-1:0] SEED  = LFSR_SEED_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_step,
    output logic [WIDTH-1:0] o_lfsr
);

    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] w_step_val;

    assign w_step_val = WIDTH'(lfsr_step(32'(r_lfsr), 32'(TAPS), WIDTH));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lfsr <= SEED;
        end else if (i_load) begin
            // An all-zero state would lock the LFSR, so it is never loaded.
            r_lfsr <= (i_load_val == '0) ? SEED : i_load_val;
        end else if (i_step) begin
            r_lfsr <= w_step_val;
        end
    end

    assign o_lfsr = r_lfsr;

endmodule

// File: rtl/lfsr_rr_server.sv
// -----------------------------------------------------------------------------
// lfsr_rr_server
// Shares one Fibonacci LFSR among N_REQ requesters through a round-robin
// arbiter. The winner receives a one-cycle registered grant carrying the
// current LFSR word; the LFSR then steps. Synchronous reseed via seed_load.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-low reset
//   req        in   level request per requester
//   seed_load  in   reload LFSR from seed_val (zero -> SEED); blocks grants
//   seed_val   in   new seed
//   gnt        out  one-hot grant pulse (registered)
//   gnt_id     out  index of granted requester (valid with rnd_valid)
//   rnd_valid  out  high exactly when gnt is non-zero
//   rnd_data   out  LFSR word delivered with the grant (pre-step value)
//   reseeding  out  high during the SEED cycle
//
// Build option: define LFSR_FREERUN_EN to step the LFSR on every cycle that
// is not a reseed, decoupling values from grant timing. Ports are unchanged.
// -----------------------------------------------------------------------------
module lfsr_rr_server
    import lfsr_pkg::*;
#(
    parameter int unsigned      N_REQ = 4,
    parameter int unsigned      WIDTH = LFSR_W,
    parameter logic [WIDTH-1:0] TAPS  = LFSR_TAPS_DEF,
    parameter logic [WIDTH-1:0] SEED  = LFSR_SEED_DEF,
    localparam int unsigned     ID_W  = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_val,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             rnd_valid,
    output logic [WIDTH-1:0] rnd_data,
    output logic             reseeding
);

    // The SEED parameter hides the SEED state literal, so states are
    // referenced through the package scope.
    state_t           r_state;
    state_t           w_state_next;
    logic [N_REQ-1:0] r_gnt;
    logic [ID_W-1:0]  r_gnt_id;
    logic [WIDTH-1:0] r_rnd_data;
    logic [ID_W-1:0]  r_ptr;

    logic [N_REQ-1:0] w_elig;
    logic [ID_W-1:0]  w_idx;
    logic [ID_W-1:0]  w_win;
    logic             w_found;
    logic             w_step;
    logic [WIDTH-1:0] w_lfsr;

    // A requester being granted this cycle cannot win the next one.
    assign w_elig = req & ~r_gnt;

    // Round-robin search starting at the pointer, wrapping N_REQ-1 -> 0.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_idx = ID_W'((32'(r_ptr) + i) % N_REQ);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    always_comb begin
        w_state_next = lfsr_pkg::IDLE;
        if (seed_load) begin
            w_state_next = lfsr_pkg::SEED;
        end else if (w_found) begin
            w_state_next = lfsr_pkg::GRANT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= lfsr_pkg::IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

`ifdef LFSR_FREERUN_EN
    // Load has priority inside the core, so reseed cycles do not step.
    assign w_step = 1'b1;
`else
    assign w_step = (w_state_next == lfsr_pkg::GRANT);
`endif

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_lfsr_core (
        .clk        (clk),
        .rst        (rst),
        .i_load     (seed_load),
        .i_load_val (seed_val),
        .i_step     (w_step),
        .o_lfsr     (w_lfsr)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_rnd_data <= '0;
            r_ptr      <= '0;
        end else begin
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_rnd_data <= '0;
            if (w_state_next == lfsr_pkg::GRANT) begin
                r_gnt      <= N_REQ'(1) << w_win;
                r_gnt_id   <= w_win;
                r_rnd_data <= w_lfsr;
                r_ptr      <= (w_win == ID_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;
            end
        end
    end

    assign gnt       = r_gnt;
    assign gnt_id    = r_gnt_id;
    assign rnd_data  = r_rnd_data;
    assign rnd_valid = (r_state == lfsr_pkg::GRANT);
    assign reseeding = (r_state == lfsr_pkg::SEED);

endmodule

// File: tb/tb_lfsr_rr_server.sv
// -----------------------------------------------------------------------------
// tb_lfsr_rr_server
// Scoreboard bench: stimulus pushes the expected grant/reseed responses in
// order; a negedge monitor pops one entry whenever the DUT presents an output
// (grant or reseeding) and compares it. Reset behaviour is checked directly.
// -----------------------------------------------------------------------------
module tb_lfsr_rr_server;

`ifdef LFSR_FREERUN_EN
    localparam bit FREERUN = 1'b1;
`else
    localparam bit FREERUN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req;
    logic       seed_load;
    logic [4:0] seed_val;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       rnd_valid;
    logic [4:0] rnd_data;
    logic       reseeding;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] id;
        logic [4:0] data;
        logic       reseed;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    lfsr_rr_server #(
        .N_REQ (4),
        .WIDTH (5),
        .TAPS  (5'b10010),
        .SEED  (5'b00001)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .seed_load (seed_load),
        .seed_val  (seed_val),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .rnd_valid (rnd_valid),
        .rnd_data  (rnd_data),
        .reseeding (reseeding)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference LFSR written out bit-wise: taps 10010 -> feedback = s[4]^s[1].
    function automatic logic [4:0] model_step(input logic [4:0] s);
        return {s[3:0], s[4] ^ s[1]};
    endfunction

    task automatic push(input logic [3:0] g, input logic [1:0] id,
                        input logic [4:0] d, input logic rs);
        exp_t e;
        e.gnt    = g;
        e.id     = id;
        e.data   = d;
        e.reseed = rs;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset mid-cycle, checks outputs cleared without a clock edge,
    // then releases one cycle later at posedge+1.
    task automatic do_reset();
        req       = '0;
        seed_load = 1'b0;
        seed_val  = '0;
        #2 rst = 1'b0;
        #1;
        check("rst_gnt",       32'(gnt),       32'd0);
        check("rst_gnt_id",    32'(gnt_id),    32'd0);
        check("rst_rnd_valid", 32'(rnd_valid), 32'd0);
        check("rst_rnd_data",  32'(rnd_data),  32'd0);
        check("rst_reseeding", 32'(reseeding), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Monitor: any visible output must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst && (gnt != 4'd0 || rnd_valid || reseeding)) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got gnt=%b data=%b reseeding=%b, required no output (t=%0t)",
                         gnt, rnd_data, reseeding, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("gnt",       32'(gnt),       32'(mon_e.gnt));
                check("gnt_id",    32'(gnt_id),    32'(mon_e.id));
                check("rnd_data",  32'(rnd_data),  32'(mon_e.data));
                check("reseeding", 32'(reseeding), 32'(mon_e.reseed));
                check("rnd_valid", 32'(rnd_valid), 32'(mon_e.gnt != 4'd0));
            end
        end
    end

    initial begin
        logic [4:0] s;
        req       = '0;
        seed_load = 1'b0;
        seed_val  = '0;

        // Single request after reset.
        do_reset();
        req = 4'b0001;
        push(4'b0001, 2'd0, 5'b00001, 1'b0);
        tick();
        req = '0;
        repeat (2) tick();

        // All four requesting continuously: rotation and LFSR sequence.
        do_reset();
        req = 4'b1111;
        push(4'b0001, 2'd0, 5'b00001, 1'b0);
        push(4'b0010, 2'd1, 5'b00010, 1'b0);
        push(4'b0100, 2'd2, 5'b00101, 1'b0);
        push(4'b1000, 2'd3, 5'b01010, 1'b0);
        push(4'b0001, 2'd0, 5'b10101, 1'b0);
        repeat (5) tick();
        req = '0;
        repeat (2) tick();

        // Single continuous requester: granted on alternate cycles only.
        do_reset();
        req = 4'b0100;
        push(4'b0100, 2'd2, 5'b00001, 1'b0);
        push(4'b0100, 2'd2, FREERUN ? 5'b00101 : 5'b00010, 1'b0);
        repeat (3) tick();
        req = '0;
        repeat (2) tick();

        // Zero seed with simultaneous request: reseed wins, seed substituted.
        do_reset();
        req       = 4'b0010;
        seed_load = 1'b1;
        seed_val  = 5'b00000;
        push(4'b0000, 2'd0, 5'b00000, 1'b1);
        push(4'b0010, 2'd1, 5'b00001, 1'b0);
        tick();
        seed_load = 1'b0;
        tick();
        req = '0;
        tick();

        // Back-to-back reseeds: last value wins; pointer is now 2, so
        // requester 0 is reached after wrapping.
        seed_load = 1'b1;
        seed_val  = 5'b00111;
        push(4'b0000, 2'd0, 5'b00000, 1'b1);
        tick();
        seed_val  = 5'b01100;
        push(4'b0000, 2'd0, 5'b00000, 1'b1);
        tick();
        seed_load = 1'b0;
        req       = 4'b0001;
        push(4'b0001, 2'd0, 5'b01100, 1'b0);
        tick();
        req = '0;
        repeat (2) tick();

        // 32 grants to one continuous requester: full period then wrap to seed.
        do_reset();
        req = 4'b0001;
        s = 5'b00001;
        for (int k = 0; k < 32; k++) begin
            push(4'b0001, 2'd0, s, 1'b0);
            s = model_step(s);
            if (FREERUN) s = model_step(s);
        end
        repeat (63) tick();
        req = '0;
        repeat (2) tick();

        // Idle for three cycles after reset, then request.
        do_reset();
        repeat (3) tick();
        req = 4'b0001;
        push(4'b0001, 2'd0, FREERUN ? 5'b01010 : 5'b00001, 1'b0);
        tick();
        req = '0;
        repeat (2) tick();

        // Asynchronous reset in the middle of a grant cycle.
        do_reset();
        req = 4'b0100;
        tick();
        #1;
        check("pre_rst_gnt", 32'(gnt), 32'b0100);
        #1 rst = 1'b0;
        #1;
        check("async_gnt",       32'(gnt),       32'd0);
        check("async_rnd_valid", 32'(rnd_valid), 32'd0);
        check("async_rnd_data",  32'(rnd_data),  32'd0);
        check("async_gnt_id",    32'(gnt_id),    32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = 4'b1111;
        push(4'b0001, 2'd0, 5'b00001, 1'b0);
        tick();
        req = '0;
        repeat (3) tick();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
